// File: rtl/iter_prefix_pkg.sv
// Shared types and constants for the iterative prefix adder.
package iter_prefix_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = $clog2(DEFAULT_WIDTH + 1);

  // bit1 = generate, bit0 = propagate
  typedef logic [1:0] gp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic gp_t gp_init(input logic ai, input logic bi);
    return {ai & bi, ai ^ bi};
  endfunction

endpackage

// File: rtl/iter_prefix_adder_if.sv
// Operand/result handshake bundle for iter_prefix_adder.
// Carries the sub line only when ITER_PREFIX_SUB_EN is defined.
interface iter_prefix_adder_if #(
  parameter int WIDTH = iter_prefix_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ITER_PREFIX_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef ITER_PREFIX_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
`ifdef ITER_PREFIX_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/gp_combine.sv
// Prefix combine cell: merges a higher (hi) span with the adjacent lower (lo) span.
module gp_combine
  import iter_prefix_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t out
);

  assign out = {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};

endmodule

// File: rtl/iter_prefix_adder.sv
// Iterative Kogge-Stone adder: one prefix stage per clock over WIDTH+1 positions.
// Optional subtract mode with ITER_PREFIX_SUB_EN.
module iter_prefix_adder
  import iter_prefix_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  iter_prefix_adder_if.slave bus
);

  localparam int NPOS   = WIDTH + 1;
  localparam int STAGES = $clog2(NPOS);
  localparam int KW     = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(STAGES - 1);

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] p_op_q, p_op_d;
  gp_t              pos_q     [NPOS];
  gp_t              pos_d     [NPOS];
  gp_t              stage_out [NPOS];
  logic [31:0]      span;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef ITER_PREFIX_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub | bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign span   = 32'd1 << k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (k_q == LAST_K) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // One combine cell per position; the lo operand is picked by the current span.
  for (genvar gi = 0; gi < NPOS; gi++) begin : g_pos
    gp_t lo;
    gp_t cmb;

    always_comb begin
      lo = '0;
      for (int j = 0; j < gi; j++) begin
        if (32'(j) + span == 32'(gi)) lo = pos_q[j];
      end
    end

    gp_combine u_combine (
      .hi  (pos_q[gi]),
      .lo  (lo),
      .out (cmb)
    );

    assign stage_out[gi] = (32'(gi) >= span) ? cmb : pos_q[gi];
  end

  always_comb begin
    p_op_d = p_op_q;
    k_d    = k_q;
    for (int i = 0; i < NPOS; i++) pos_d[i] = pos_q[i];

    if (accept) begin
      p_op_d   = bus.a ^ b_eff;
      k_d      = '0;
      pos_d[0] = {cin_eff, 1'b0};
      for (int i = 0; i < WIDTH; i++) pos_d[i+1] = gp_init(bus.a[i], b_eff[i]);
    end else if (state_q == RUN) begin
      for (int i = 0; i < NPOS; i++) pos_d[i] = stage_out[i];
      k_d = (k_q == LAST_K) ? '0 : k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      p_op_q <= '0;
      for (int i = 0; i < NPOS; i++) pos_q[i] <= '0;
    end else begin
      k_q    <= k_d;
      p_op_q <= p_op_d;
      for (int i = 0; i < NPOS; i++) pos_q[i] <= pos_d[i];
    end
  end

  // Final generate of position i is the carry into bit i.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) bus.sum[i] = p_op_q[i] ^ pos_q[i][1];
    bus.cout = pos_q[WIDTH][1];
  end

endmodule

// File: tb/tb_iter_prefix_adder.sv
// Directed and back-to-back checks for iter_prefix_adder.
// Subtract vectors are exercised when ITER_PREFIX_SUB_EN is defined.
module tb_iter_prefix_adder;
  import iter_prefix_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  iter_prefix_adder_if #(.WIDTH(W)) bus ();

  iter_prefix_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sub(input logic s);
`ifdef ITER_PREFIX_SUB_EN
    bus.sub = s;
`else
    if (s) check("sub_unsupported", 32'd1, 32'd0);
`endif
  endtask

  // Accept one operand set and return edges from accept to out_valid (0 = timeout).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input string tag, output int lat);
    int waited = 0;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a; bus.b = b; bus.cin = c; set_sub(s);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic s, input string tag,
                       input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    start_op(a, b, c, s, tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    $display("[TB] %s a=0x%04h b=0x%04h cin=%0d sub=%0d -> sum=0x%04h cout=%0d", tag, a, b, c, s, bus.sum, bus.cout);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [16:0] expq[$];
    logic [16:0] e;
    logic [16:0] pushed;
    int accepts, results, last_acc;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    set_sub(1'b0);

    // Reset state
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap", 16'h0000, 1'b1);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, "mix", 16'h5556, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, "msb", 16'h0001, 1'b1);

    // Result held under back-pressure while new operands are offered
    start_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0, "hold", lat);
    check("hold_latency", 32'(lat), 32'd5);
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1; bus.in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.sum), 32'h0FFF);
      check("hold_cout", 32'(bus.cout), 32'd0);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    $display("[TB] hold a=0x00f0 b=0x0f0f -> sum=0x%04h held 3 cycles", bus.sum);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("hold_release", 32'(bus.in_ready), 32'd1);

    // Reset asserted while stage 2 is pending
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_sum", 32'(bus.sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("[TB] abort reset mid-run");
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, "post_rst", 16'h0002, 1'b0);

`ifdef ITER_PREFIX_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_neg", 16'hFFFE, 1'b0);
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_pos", 16'h0002, 1'b1);
`endif

    // Back-to-back stream against an arithmetic reference
    accepts = 0; results = 0; last_acc = -1;
    bus.out_ready = 1'b1;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 1000 * 7 + 100; cyc++) begin
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          check("b2b_spurious", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("b2b_sum", 32'(bus.sum), 32'(e[15:0]));
          check("b2b_cout", 32'(bus.cout), 32'(e[16]));
          results++;
        end
      end
      if (bus.in_ready && bus.in_valid) begin
        pushed = {1'b0, bus.a} + {1'b0, bus.b} + 17'(bus.cin);
`ifdef ITER_PREFIX_SUB_EN
        if (bus.sub) pushed = {1'b0, bus.a} + {1'b0, ~bus.b} + 17'd1;
`endif
        expq.push_back(pushed);
        if (last_acc >= 0) check("b2b_gap", 32'(cyc - last_acc), 32'd7);
        last_acc = cyc;
        accepts++;
      end else if (accepts >= 1000) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
`ifdef ITER_PREFIX_SUB_EN
        bus.sub = 1'($urandom);
`endif
      end
      if (results >= 1000) break;
      tick();
    end
    check("b2b_count", 32'(results), 32'd1000);
    $display("[TB] back-to-back %0d accepts, %0d results", accepts, results);
    bus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_prefix_adder.md
ITER_PREFIX_ADDER -- requirements
Module: iter_prefix_adder

Interface
REQ-001 SHALL expose parameter WIDTH, default 16, operand width; 17 prefix positions at the default.
REQ-002 SHALL expose clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL expose rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL expose in_valid  input  1  operand set present.
REQ-005 SHALL expose in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL expose a, b  input  WIDTH each  operands.
REQ-007 SHALL expose cin  input  1  carry-in.
REQ-008 SHALL expose out_valid  output  1  result present.
REQ-009 SHALL expose out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL expose sum  output  WIDTH  result.
REQ-011 SHALL expose cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 SHALL hold one (g,p) pair per position: bit1 = generate, bit0 = propagate; position 0 = (cin,0); position i+1 = (a[i]&b[i], a[i]^b[i]).
REQ-013 SHALL use the combine rule: g = hi.g | (hi.p & lo.g); p = hi.p & lo.p.
REQ-014 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready high only in IDLE.
REQ-016 IDLE: when in_valid is high, SHALL capture the initial pairs and the operand propagate vector, clear the stage counter k, and go to RUN.
REQ-017 RUN, stage k = 0..log2(WIDTH+1) rounded up minus 1 (0..4 at default): position i >= 2^k SHALL become combine(hi = pos[i], lo = pos[i - 2^k]); positions below 2^k pass unchanged.
REQ-018 SHALL leave RUN for DONE after the last stage; for the default, out_valid rises 5 edges after the accept edge.
REQ-019 SHALL form the result as sum[i] = p_op[i] ^ G[i] and cout = G[WIDTH], where G is the final generate of each position.
REQ-020 DONE: SHALL hold out_valid, sum and cout stable until out_ready is high, then return to IDLE on that edge.
REQ-021 SHALL ignore in_valid outside IDLE, so operands are never overwritten mid-operation.
REQ-022 out_ready outside DONE SHALL have no effect.

Reset
REQ-023 When rst_n is low, SHALL immediately force state IDLE, k=0, out_valid=0, sum=0, cout=0, and all pair registers to 0.
REQ-024 Reset during RUN or DONE SHALL abort the operation with no result emitted.
REQ-025 in_ready SHALL be 1 during and after reset.

Configuration
REQ-026 With ITER_PREFIX_SUB_EN defined: SHALL add input port sub (1 bit), sampled at accept; when sub=1, b is inverted and the carry-in forced to 1, yielding a-b.
REQ-027 Without ITER_PREFIX_SUB_EN: SHALL have no sub port and compute a+b+cin only.

Structure
REQ-028 Package iter_prefix_pkg SHALL hold the gp_t 2-bit pair typedef, the state enum, the default WIDTH and the stage count.
REQ-029 SHALL implement the combine rule as the single sub-module gp_combine, replicated across positions.

Verification
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, out_valid 5 edges after accept.
REQ-031 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-032 Result pending with out_ready low for 3 cycles -> sum/cout/out_valid stable; in_ready=0; new in_valid ignored.
REQ-033 rst_n pulsed low at RUN stage 2 -> out_valid=0 and in_ready=1 immediately; next operands 0x0001+0x0001 -> sum=0x0002.
REQ-034 With ITER_PREFIX_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-035 Back-to-back: out_ready=1 and in_valid=1 held -> one accept every 7 cycles; results match a random-operand reference model over 1000 vectors.
